// File: rtl/mem_io_bridge_pkg.sv
// ============================================================================
// Module      : mem_io_bridge_pkg
// Description : I/O address map shared by the memory-side bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_io_bridge_pkg;

  localparam logic [17:0] IO_UART     = 18'h30000;
  localparam logic [17:0] IO_END      = 18'h30004;
  localparam logic [17:0] IO_CYC_BASE = 18'h30008;
  localparam logic [1:0]  IO_SEL      = 2'b11;

  function automatic logic is_io(input logic [17:0] addr);
    return addr[17:16] == IO_SEL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_io_bridge_tx.sv
// ============================================================================
// Module      : tx_fifo
// Description : Circular-buffer FIFO with wrap-bit pointers and a live count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [PW-1:0]    o_count,
  output logic [PW-1:0]    o_count_next,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_count_next = r_count + PW'(w_push) - PW'(w_pop);
  assign o_count      = r_count;
  assign o_rdata      = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= o_count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/mem_io_bridge.sv
// ============================================================================
// Module      : mem_io_bridge
// Description : Byte-bus RAM/MMIO decode, UART TX buffering, program-end latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int RAM_ADDR_WID = 17,
  parameter int FIFO_DEPTH   = 8,
  parameter int FULL_MARGIN  = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [31:0]             mem_a,
  input  logic [7:0]              mem_dout,
  input  logic                    mem_wr,
  output logic [7:0]              mem_din,
  output logic                    io_buffer_full,
  output logic [RAM_ADDR_WID-1:0] ram_a,
  output logic                    ram_we,
  output logic [7:0]              ram_wdata,
  input  logic [7:0]              ram_rdata,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    tx_overflow,
  output logic                    program_end,
  output logic [7:0]              program_end_code
);

  localparam int              c_PW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_PW-1:0] c_FULL_TH = c_PW'(FIFO_DEPTH - FULL_MARGIN);

  logic [17:0]     w_addr;
  logic            w_io;
  logic            w_io_wr;
  logic            w_push_req;
  logic            w_pop;
  logic [7:0]      w_io_rdata;
  logic [c_PW-1:0] w_tx_count;
  logic [c_PW-1:0] w_tx_count_next;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_unused;
  logic            r_io_q;
  logic [7:0]      r_io_rdata_q;
  logic [31:0]     r_cyc;

  assign w_addr   = mem_a[17:0];
  assign w_io     = is_io(w_addr);
  assign w_unused = ^mem_a[31:18];

  assign ram_a     = mem_a[RAM_ADDR_WID-1:0];
  assign ram_we    = mem_wr && rdy_in && !w_io;
  assign ram_wdata = mem_dout;

  assign w_io_wr    = mem_wr && rdy_in && w_io;
  assign w_push_req = w_io_wr && (w_addr == IO_UART);
  assign tx_valid   = !w_fifo_empty;
  assign w_pop      = tx_valid && tx_ready;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .i_clk        (clk_in),
    .i_rst_n      (rst_in),
    .i_push       (w_push_req),
    .i_wdata      (mem_dout),
    .i_pop        (tx_ready),
    .o_rdata      (tx_data),
    .o_count      (w_tx_count),
    .o_count_next (w_tx_count_next),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  // Reads have no side effects: the CPU holds the address for many cycles.
  always_comb begin
    w_io_rdata = 8'h00;
    if (w_addr == IO_UART) begin
      w_io_rdata = 8'(w_tx_count);
    end else if (w_addr == IO_END) begin
      w_io_rdata = {7'b0, program_end};
    end else if (w_addr[17:2] == IO_CYC_BASE[17:2]) begin
      case (w_addr[1:0])
        2'd0:    w_io_rdata = r_cyc[7:0];
        2'd1:    w_io_rdata = r_cyc[15:8];
        2'd2:    w_io_rdata = r_cyc[23:16];
        default: w_io_rdata = r_cyc[31:24];
      endcase
    end
  end

  assign mem_din = r_io_q ? r_io_rdata_q : ram_rdata;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_io_q           <= 1'b0;
      r_io_rdata_q     <= 8'h00;
      r_cyc            <= 32'h0;
      io_buffer_full   <= 1'b0;
      tx_overflow      <= 1'b0;
      program_end      <= 1'b0;
      program_end_code <= 8'h00;
    end else begin
      r_io_q         <= w_io;
      r_io_rdata_q   <= w_io_rdata;
      r_cyc          <= r_cyc + 32'h1;
      io_buffer_full <= (w_tx_count_next >= c_FULL_TH);
      if (w_push_req && w_fifo_full && !w_pop) tx_overflow <= 1'b1;
      if (w_io_wr && (w_addr == IO_END)) begin
        program_end      <= 1'b1;
        program_end_code <= mem_dout;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
// ============================================================================
// Module      : tb_mem_io_bridge
// Description : Scoreboard bench for mem_io_bridge with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        tx_overflow;
  logic        program_end;
  logic [7:0]  program_end_code;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  ram_mem [0:131071];
  logic [31:0] tb_cyc;

  always #5 clk_in = ~clk_in;

  mem_io_bridge dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .mem_a            (mem_a),
    .mem_dout         (mem_dout),
    .mem_wr           (mem_wr),
    .mem_din          (mem_din),
    .io_buffer_full   (io_buffer_full),
    .ram_a            (ram_a),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready),
    .tx_overflow      (tx_overflow),
    .program_end      (program_end),
    .program_end_code (program_end_code)
  );

  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_a] <= ram_wdata;
    ram_rdata <= ram_mem[ram_a];
  end

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) tb_cyc <= 32'h0;
    else         tb_cyc <= tb_cyc + 32'h1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Handshake completes on the next rising edge; inputs are stable here.
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                  chk("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    end
  end

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_dout = d;
    mem_wr   = 1'b1;
    cycle();
    mem_wr   = 1'b0;
    mem_a    = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
    mem_a  = a;
    mem_wr = 1'b0;
    rd_q.push_back(exp);
    cycle();
    chk(tag, {24'h0, mem_din}, {24'h0, rd_q.pop_front()});
    mem_a  = 32'h0;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 64 && tx_q.size() != 0; i++) cycle();
    chk("drain_left", tx_q.size(), 0);
    tx_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_full", {31'h0, io_buffer_full}, 0);
    chk("rst_ovf", {31'h0, tx_overflow}, 0);
    chk("rst_end", {31'h0, program_end}, 0);
    chk("rst_code", {24'h0, program_end_code}, 0);
    chk("rst_din", {24'h0, mem_din}, {24'h0, ram_rdata});
    repeat (3) cycle();
    rst_in = 1'b1;
    cycle();

    // RAM write then read back
    mem_a = 32'h0000_0123; mem_dout = 8'hA5; mem_wr = 1'b1;
    #1;
    chk("ram_we", {31'h0, ram_we}, 1);
    chk("ram_a", {15'h0, ram_a}, 32'h123);
    cycle();
    mem_wr = 1'b0;
    rd("ram_rd", 32'h0000_0123, 8'hA5);

    // UART stream and near-full flag
    for (int i = 0; i < 5; i++) begin
      wr(32'h0003_0000, 8'(8'h41 + i));
      tx_q.push_back(8'(8'h41 + i));
      if (i == 0) chk("tx_valid_n1", {31'h0, tx_valid}, 1);
    end
    chk("full_at5", {31'h0, io_buffer_full}, 0);
    rd("count5", 32'h0003_0000, 8'd5);
    wr(32'h0003_0000, 8'h46);
    tx_q.push_back(8'h46);
    chk("full_at6", {31'h0, io_buffer_full}, 1);
    drain();
    chk("full_drained", {31'h0, io_buffer_full}, 0);

    // Fill, push+pop on full, then overflow
    for (int i = 0; i < 8; i++) begin
      wr(32'h0003_0000, 8'(8'h50 + i));
      tx_q.push_back(8'(8'h50 + i));
    end
    chk("ovf_after8", {31'h0, tx_overflow}, 0);
    rd("count8", 32'h0003_0000, 8'd8);
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h59);
    tx_q.push_back(8'h59);
    tx_ready = 1'b0;
    chk("ovf_pushpop", {31'h0, tx_overflow}, 0);
    rd("count8_pp", 32'h0003_0000, 8'd8);
    wr(32'h0003_0000, 8'h5A);
    chk("ovf_set", {31'h0, tx_overflow}, 1);
    rd("count8_drop", 32'h0003_0000, 8'd8);
    drain();

    // Program end
    wr(32'h0003_0004, 8'h07);
    chk("pend", {31'h0, program_end}, 1);
    chk("pend_code", {24'h0, program_end_code}, 32'h07);
    rd("pend_rd", 32'h0003_0004, 8'h01);

    // Stall: no push, no RAM write, no end update; counter keeps running
    rdy_in = 1'b0;
    mem_a = 32'h0000_0200; mem_dout = 8'h11; mem_wr = 1'b1;
    #1;
    chk("stall_ram_we", {31'h0, ram_we}, 0);
    cycle();
    mem_wr = 1'b0;
    wr(32'h0003_0000, 8'h99);
    wr(32'h0003_0004, 8'h33);
    chk("stall_code", {24'h0, program_end_code}, 32'h07);
    chk("stall_tx_valid", {31'h0, tx_valid}, 0);
    rd("stall_count", 32'h0003_0000, 8'd0);
    rd("cyc_b0_a", 32'h0003_0008, tb_cyc[7:0]);
    repeat (5) cycle();
    rd("cyc_b0_b", 32'h0003_0008, tb_cyc[7:0]);
    rd("cyc_b1", 32'h0003_0009, tb_cyc[15:8]);
    rdy_in = 1'b1;

    // Reset with bytes queued
    for (int i = 0; i < 3; i++) begin
      wr(32'h0003_0000, 8'(8'h61 + i));
      tx_q.push_back(8'(8'h61 + i));
    end
    chk("pre_rst_valid", {31'h0, tx_valid}, 1);
    rst_in = 1'b0;
    #1;
    chk("rst_async_valid", {31'h0, tx_valid}, 0);
    tx_q.delete();
    repeat (2) cycle();
    rst_in = 1'b1;
    chk("post_ovf", {31'h0, tx_overflow}, 0);
    chk("post_end", {31'h0, program_end}, 0);
    chk("post_code", {24'h0, program_end_code}, 0);
    chk("post_full", {31'h0, io_buffer_full}, 0);
    rd("post_count", 32'h0003_0000, 8'd0);
    rd("post_end_rd", 32'h0003_0004, 8'd0);
    rd("post_cyc0", 32'h0003_0008, tb_cyc[7:0]);
    rd("post_cyc3", 32'h0003_000B, tb_cyc[31:24]);
    rd("io_other", 32'h0003_000C, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
